regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the register file between two writeback sources.
- Requester A is the ALU writeback; requester B is the load/memory writeback.
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains the slots onto registered rw/wdat/wren outputs, which drive the register file write port directly.

Parameters:
BITSIZE, 16, data width; matches the register file word width.
ADDSIZE, 4, register address width; 2**ADDSIZE registers.

Ports:
clk  input  1  clock; all state changes on posedge clk.
rst  input  1  synchronous reset, active-high.
a_valid  input  1  requester A has a write.
a_ready  output  1  slot A can accept this cycle.
a_addr  input  ADDSIZE  A destination register.
a_data  input  BITSIZE  A write data.
b_valid  input  1  requester B has a write.
b_ready  output  1  slot B can accept this cycle.
b_addr  input  ADDSIZE  B destination register.
b_data  input  BITSIZE  B write data.
rw  output  ADDSIZE  register file write address (registered).
wdat  output  BITSIZE  register file write data (registered).
wren  output  1  register file write enable (registered).
busy  output  1  any slot pending or wren high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: pend_a=0, pend_b=0, wren=0, rw=0, wdat=0, rr_last=B (so A wins the first tie), busy=0.
  - rst asserted mid-operation discards pending slots and any in-flight wren on that edge.
  - No partial writes.
- Slot x (A or B) holds {pend_x, addr_x, data_x}.
- Ready: x_ready = ~pend_x | grant_x. A full slot accepts again in the same cycle it is granted.
  - x_ready is driven low while rst is high.
- Accept: when x_valid & x_ready at a posedge, the slot loads addr/data and pend_x=1.
  - Simultaneous grant and accept leaves pend_x=1 with the new contents.
- Grant (combinational):
  - Only one slot pending: grant that slot.
  - Both pending: grant the slot not equal to rr_last.
  - rr_last updates to the granted slot on every grant.
  - Granted slot clears pend_x at the edge unless it reloads the same edge.
- Output: at the edge of a grant, wren<=1, rw<=addr_g, wdat<=data_g. With no grant, wren<=0; rw/wdat hold their values.
- Latency:
  - Handshake at edge N -> wren high after edge N+1 -> register file written at edge N+2.
  - Throughput is one write per cycle in aggregate.
  - With both slots busy, each requester sustains one write every 2 cycles.
- Same-address conflict: both slots targeting the same register are written in grant order. The later grant overwrites; neither is dropped.
- A valid held while ready=0 must keep addr/data stable. The arbiter never drops a pending write.
- busy = pend_a | pend_b | wren.

Optional Feature:
Macro WB_R0_DROP_EN.
- Defined: a write to address 0 is accepted normally (handshake completes, slot cleared on grant), but the output stage forces wren<=0 for it. Register 0 therefore stays zero, per MIPS $zero.
- Undefined: address 0 is written like any other register.

Decomposition:
- Package regfile_pkg: default BITSIZE/ADDSIZE constants; requester id typedef (REQ_A, REQ_B); ZERO_REG constant = 0.
- Sub-module wb_hold_slot: one-entry holding register with valid/ready, load and clear inputs. Instantiated twice.
- Arbiter and output register stay in the top module.

Test Plan:
- rst=1 for 2 cycles with a_valid=b_valid=1 -> wren=0, a_ready=b_ready=0, busy=0. After release, rw=0 and wdat=0.
- Single A write (addr 5, data 16'h1234) at edge N -> wren=1, rw=5, wdat=16'h1234 for exactly one cycle after edge N+1. busy falls afterward.
- A and B valid every cycle (A addr 1, data 16'hAAAA; B addr 2, data 16'hBBBB) -> wren stays high. Grants alternate A,B,A,B. Each ready toggles every other cycle.
- Both pending to addr 7 (A 16'h0001, B 16'h0002), rr_last=B -> writes A then B. The final write carries 16'h0002.
- B in flight, rst pulsed for 1 cycle -> wren=0 on the next edge, pend cleared, no write of B's data occurs, next tie goes to A.
- WB_R0_DROP_EN defined, A writes addr 0, data 16'hFFFF -> handshake completes, wren stays 0. Without the macro -> wren=1, rw=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file writeback arbiter.
package regfile_pkg;
    localparam int DEF_BITSIZE = 16;
    localparam int DEF_ADDSIZE = 4;
    localparam int ZERO_REG    = 0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
module wb_hold_slot #(
    parameter int BITSIZE = 16,
    parameter int ADDSIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    output logic               ready,
    input  logic [ADDSIZE-1:0] addr,
    input  logic [BITSIZE-1:0] data,
    input  logic               grant,
    output logic               pend,
    output logic [ADDSIZE-1:0] addr_q,
    output logic [BITSIZE-1:0] data_q
);
    logic               pend_reg;
    logic [ADDSIZE-1:0] addr_reg;
    logic [BITSIZE-1:0] data_reg;
    logic               load;

    // A granted slot frees up this cycle, so it can take a new write back-to-back.
    assign ready = ~rst & (~pend_reg | grant);
    assign load  = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (load) begin
            pend_reg <= 1'b1;
            addr_reg <= addr;
            data_reg <= data;
        end else if (grant) begin
            pend_reg <= 1'b0;
        end
    end

    assign pend   = pend_reg;
    assign addr_q = addr_reg;
    assign data_q = data_reg;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writeback.
// Optional WB_R0_DROP_EN: writes to register 0 are accepted but never reach the write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int ADDSIZE = DEF_ADDSIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [ADDSIZE-1:0] a_addr,
    input  logic [BITSIZE-1:0] a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [ADDSIZE-1:0] b_addr,
    input  logic [BITSIZE-1:0] b_data,
    output logic [ADDSIZE-1:0] rw,
    output logic [BITSIZE-1:0] wdat,
    output logic               wren,
    output logic               busy
);
    logic               pend_a, pend_b;
    logic [ADDSIZE-1:0] addr_a, addr_b;
    logic [BITSIZE-1:0] data_a, data_b;
    logic               grant_a, grant_b;
    logic [ADDSIZE-1:0] addr_g;
    logic [BITSIZE-1:0] data_g;
    req_id_t            rr_last_reg;
    logic [ADDSIZE-1:0] rw_reg;
    logic [BITSIZE-1:0] wdat_reg;
    logic               wren_reg;

    wb_hold_slot #(.BITSIZE(BITSIZE), .ADDSIZE(ADDSIZE)) u_slot_a (
        .clk(clk), .rst(rst), .valid(a_valid), .ready(a_ready),
        .addr(a_addr), .data(a_data), .grant(grant_a),
        .pend(pend_a), .addr_q(addr_a), .data_q(data_a)
    );

    wb_hold_slot #(.BITSIZE(BITSIZE), .ADDSIZE(ADDSIZE)) u_slot_b (
        .clk(clk), .rst(rst), .valid(b_valid), .ready(b_ready),
        .addr(b_addr), .data(b_data), .grant(grant_b),
        .pend(pend_b), .addr_q(addr_b), .data_q(data_b)
    );

    // On a tie, the slot that did not win last time goes first.
    assign grant_a = pend_a & (~pend_b | (rr_last_reg == REQ_B));
    assign grant_b = pend_b & ~grant_a;
    assign addr_g  = grant_a ? addr_a : addr_b;
    assign data_g  = grant_a ? data_a : data_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_reg <= REQ_B;
            rw_reg      <= '0;
            wdat_reg    <= '0;
            wren_reg    <= 1'b0;
        end else if (grant_a | grant_b) begin
            rr_last_reg <= grant_a ? REQ_A : REQ_B;
            rw_reg      <= addr_g;
            wdat_reg    <= data_g;
`ifdef WB_R0_DROP_EN
            wren_reg    <= (addr_g != ADDSIZE'(ZERO_REG));
`else
            wren_reg    <= 1'b1;
`endif
        end else begin
            wren_reg    <= 1'b0;
        end
    end

    assign rw   = rw_reg;
    assign wdat = wdat_reg;
    assign wren = wren_reg;
    assign busy = pend_a | pend_b | wren_reg;
endmodule
